// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target-side shifter: state encoding,
// sample/shift edge selection and the default underrun fill word.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // Widest supported word; the top truncates this to its own WIDTH.
    localparam logic [15:0] FILL_ALL_ONES = 16'hFFFF;

    // Data is sampled on the rising SCLK edge when cpol and cpha agree,
    // otherwise on the falling edge; shifting happens on the other edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus an edge register that
// turns level changes of the synchronised signal into one-cycle pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic edge_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            edge_q <= RST_VAL;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            edge_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~edge_q;
    assign fall  = ~s2_q & edge_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI target shifter: oversampled SCLK/SS_N/MOSI, all CPOL/CPHA modes, LSB/MSB
// first, valid/ready transmit holding register. Option: SPI_SLAVE_OVERRUN_EN.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = WIDTH'(FILL_ALL_ONES)
) (
    input  logic             PClk,
    input  logic             PRESET,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsbfe,
    input  logic             sclk_in,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic             rx_ack,
    output logic             rx_overrun
`endif
);

    localparam int CW = $clog2(WIDTH);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_lvl;
    logic ss_rise;
    logic ss_fall;
    logic mosi_s1_q;
    logic mosi_s2_q;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk   (PClk),
        .srst  (PRESET),
        .d     (sclk_in),
        .level (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk   (PClk),
        .srst  (PRESET),
        .d     (ss_n),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge PClk) begin
        if (PRESET) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    spi_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             skip_q, skip_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             miso_q, miso_d;

    logic             sample_pulse;
    logic             shift_pulse;
    logic             accept;
    logic             load;
    logic             complete;
    logic [WIDTH-1:0] rx_shifted;
    logic [WIDTH-1:0] tx_shifted;

    assign sample_pulse = sample_on_rise(cpol, cpha) ? sclk_rise : sclk_fall;
    assign shift_pulse  = sample_on_rise(cpol, cpha) ? sclk_fall : sclk_rise;
    assign accept       = tx_valid & ~full_q;
    assign rx_shifted   = lsbfe ? {mosi_s2_q, rx_sh_q[WIDTH-1:1]}
                                : {rx_sh_q[WIDTH-2:0], mosi_s2_q};
    assign tx_shifted   = lsbfe ? {1'b0, tx_sh_q[WIDTH-1:1]}
                                : {tx_sh_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skip_d    = skip_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        hold_d    = hold_q;
        full_d    = full_q;
        rx_data_d = rx_data_q;
        load      = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                    cnt_d   = '0;
                    skip_d  = cpha;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    skip_d  = 1'b0;
                end else if (!ss_lvl) begin
                    if (sample_pulse) begin
                        rx_sh_d = rx_shifted;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            complete  = 1'b1;
                            rx_data_d = rx_shifted;
                            cnt_d     = '0;
                            load      = 1'b1;
                            skip_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (shift_pulse) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_sh_d = tx_shifted;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load sees the pre-cycle holding register; an accept can only
        // happen when it is empty, so the new word waits for the next load.
        if (load) begin
            tx_sh_d = full_q ? hold_q : FILL;
        end
        if (accept) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end else if (load && full_q) begin
            full_d = 1'b0;
        end

        miso_d = 1'b0;
        if (state_d == ACTIVE) begin
            miso_d = lsbfe ? tx_sh_d[0] : tx_sh_d[WIDTH-1];
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_overrun_q, rx_overrun_d;

    always_comb begin
        rx_valid_d   = complete | (rx_valid_q & ~rx_ack);
        rx_overrun_d = ~rx_ack & (rx_overrun_q | (complete & rx_valid_q));
    end

    always_ff @(posedge PClk) begin
        if (PRESET) begin
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_overrun = rx_overrun_q;
`else
    always_comb begin
        rx_valid_d = complete;
    end
`endif

    always_ff @(posedge PClk) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            skip_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            skip_q     <= skip_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = (state_q == ACTIVE);
    assign busy     = (state_q == ACTIVE);
    assign tx_ready = ~full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter acting as the SPI master; sequences are
// kept in wire order (first bit on the wire in the MSB of the vector).
module tb_spi_slave_shifter;

    logic       PClk = 1'b0;
    logic       PRESET = 1'b1;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       lsbfe = 1'b0;
    logic       sclk_in = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack = 1'b1;
    logic       rx_overrun;
`endif

    spi_slave_shifter #(.WIDTH(8)) dut (
        .PClk     (PClk),
        .PRESET   (PRESET),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsbfe    (lsbfe),
        .sclk_in  (sclk_in),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun)
`endif
    );

    always #5 PClk = ~PClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // rx_valid monitor: counts high cycles and rising pulses.
    int   rv_high   = 0;
    int   rv_pulses = 0;
    logic rv_prev   = 1'b0;
    always @(negedge PClk) begin
        if (rx_valid) begin
            rv_high++;
            if (!rv_prev) rv_pulses++;
        end
        rv_prev = rx_valid;
    end

    logic st_busy, st_oe, st_ready, end_oe, end_busy, end_miso;

    task automatic half();
        repeat (8) @(negedge PClk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge PClk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge PClk);
            n++;
        end
        if (n >= 200) check("tx_accept", {31'd0, tx_ready}, 32'd1);
        @(negedge PClk);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                        input logic [15:0] mseq, input int nbits, output logic [15:0] sseq);
        sseq    = '0;
        cpol    = p_cpol;
        cpha    = p_cpha;
        lsbfe   = p_lsb;
        sclk_in = p_cpol;
        half();
        ss_n = 1'b0;
        if (!p_cpha) mosi = mseq[nbits-1];
        half();
        st_busy  = busy;
        st_oe    = miso_oe;
        st_ready = tx_ready;
        for (int i = 0; i < nbits; i++) begin
            if (p_cpha) begin
                sclk_in = ~p_cpol;
                mosi    = mseq[nbits-1-i];
                half();
                sseq    = {sseq[14:0], miso};
                sclk_in = p_cpol;
                half();
            end else begin
                sseq    = {sseq[14:0], miso};
                sclk_in = ~p_cpol;
                half();
                sclk_in = p_cpol;
                if (i + 1 < nbits) mosi = mseq[nbits-2-i];
                half();
            end
        end
        ss_n = 1'b1;
        repeat (4) @(negedge PClk);
        end_oe   = miso_oe;
        end_busy = busy;
        end_miso = miso;
        half();
        $display("xfer cpol=%0d cpha=%0d lsbfe=%0d bits=%0d mosi=0x%0h miso=0x%0h rx_data=0x%0h",
                 p_cpol, p_cpha, p_lsb, nbits, mseq, sseq, rx_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        int          p0;
        int          h0;

        repeat (4) @(negedge PClk);
        PRESET = 1'b0;
        @(negedge PClk);
        check("rst_miso",     {31'd0, miso},     32'd0);
        check("rst_miso_oe",  {31'd0, miso_oe},  32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data",  {24'd0, rx_data},  32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);

        // Mode 0, MSB first, pre-loaded 0xA5, master sends 0x3C.
        push_tx(8'hA5);
        check("m0_tx_ready_held", {31'd0, tx_ready}, 32'd0);
        p0 = rv_pulses; h0 = rv_high;
        xfer(1'b0, 1'b0, 1'b0, 16'h003C, 8, s);
        check("m0_miso",         {24'd0, s[7:0]},   32'hA5);
        check("m0_rx_data",      {24'd0, rx_data},  32'h3C);
        check("m0_rx_pulses",    rv_pulses - p0,    32'd1);
        check("m0_rx_high",      rv_high - h0,      32'd1);
        check("m0_ready_start",  {31'd0, st_ready}, 32'd1);
        check("m0_busy_start",   {31'd0, st_busy},  32'd1);
        check("m0_oe_start",     {31'd0, st_oe},    32'd1);
        check("m0_oe_end",       {31'd0, end_oe},   32'd0);

        // Modes 1..3, MSB first, tx 0x81, master sends 0x7E.
        for (int m = 1; m < 4; m++) begin
            logic [1:0] mv;
            mv = 2'(m);
            push_tx(8'h81);
            p0 = rv_pulses;
            xfer(mv[1], mv[0], 1'b0, 16'h007E, 8, s);
            check($sformatf("mode%0d_miso", m),      {24'd0, s[7:0]},  32'h81);
            check($sformatf("mode%0d_rx_data", m),   {24'd0, rx_data}, 32'h7E);
            check($sformatf("mode%0d_rx_pulses", m), rv_pulses - p0,   32'd1);
        end

        // LSB first, mode 0: tx 0x01 -> wire 1,0,0,0,0,0,0,0; master sends 0x80 LSB first.
        push_tx(8'h01);
        xfer(1'b0, 1'b0, 1'b1, 16'h0001, 8, s);
        check("lsb_miso_seq", {24'd0, s[7:0]},  32'h80);
        check("lsb_rx_data",  {24'd0, rx_data}, 32'h80);

        // Back-to-back words, second word supplied during the first.
        push_tx(8'h11);
        p0 = rv_pulses; h0 = rv_high;
        fork
            xfer(1'b0, 1'b0, 1'b0, 16'hC35A, 16, s);
            begin
                repeat (60) @(negedge PClk);
                push_tx(8'h22);
            end
        join
        check("b2b_miso",      {16'd0, s},       32'h1122);
        check("b2b_rx_pulses", rv_pulses - p0,   32'd2);
        check("b2b_rx_high",   rv_high - h0,     32'd2);
        check("b2b_rx_data",   {24'd0, rx_data}, 32'h5A);

        // Back-to-back with underrun on the second word.
        push_tx(8'h11);
        p0 = rv_pulses;
        xfer(1'b0, 1'b0, 1'b0, 16'h0F0F, 16, s);
        check("underrun_miso",      {16'd0, s},       32'h11FF);
        check("underrun_rx_pulses", rv_pulses - p0,   32'd2);
        check("underrun_rx_data",   {24'd0, rx_data}, 32'h0F);

        // Abort after 5 bits; a word pushed mid-transfer must survive it.
        p0 = rv_pulses;
        fork
            xfer(1'b0, 1'b0, 1'b0, 16'h0015, 5, s);
            begin
                repeat (40) @(negedge PClk);
                push_tx(8'h96);
            end
        join
        check("abort_miso",       {27'd0, s[4:0]},   32'h1F);
        check("abort_rx_pulses",  rv_pulses - p0,    32'd0);
        check("abort_oe_4clk",    {31'd0, end_oe},   32'd0);
        check("abort_busy_4clk",  {31'd0, end_busy}, 32'd0);
        check("abort_miso_4clk",  {31'd0, end_miso}, 32'd0);
        check("abort_hold_kept",  {31'd0, tx_ready}, 32'd0);
        p0 = rv_pulses;
        xfer(1'b0, 1'b0, 1'b0, 16'h0069, 8, s);
        check("post_abort_miso",    {24'd0, s[7:0]},  32'h96);
        check("post_abort_rx_data", {24'd0, rx_data}, 32'h69);
        check("post_abort_pulses",  rv_pulses - p0,   32'd1);

        // PRESET mid-word.
        push_tx(8'h33);
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sclk_in = 1'b0;
        half();
        ss_n = 1'b0;
        half();
        sclk_in = 1'b1; half();
        sclk_in = 1'b0; half();
        sclk_in = 1'b1; repeat (4) @(negedge PClk);
        PRESET = 1'b1;
        @(negedge PClk);
        PRESET = 1'b0;
        check("prst_miso",     {31'd0, miso},     32'd0);
        check("prst_miso_oe",  {31'd0, miso_oe},  32'd0);
        check("prst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("prst_rx_data",  {24'd0, rx_data},  32'd0);
        check("prst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("prst_busy",     {31'd0, busy},     32'd0);
        $display("preset mid-word applied");
        ss_n = 1'b1; sclk_in = 1'b0;
        half(); half();

        push_tx(8'hC3);
        xfer(1'b0, 1'b0, 1'b0, 16'h0024, 8, s);
        check("post_rst_miso",    {24'd0, s[7:0]},  32'hC3);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h24);

`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack = 1'b0;
        xfer(1'b0, 1'b0, 1'b0, 16'hA1B2, 16, s);
        check("ovr_flag",     {31'd0, rx_overrun}, 32'd1);
        check("ovr_rx_valid", {31'd0, rx_valid},   32'd1);
        check("ovr_rx_data",  {24'd0, rx_data},    32'hB2);
        rx_ack = 1'b1;
        @(negedge PClk);
        check("ack_rx_valid", {31'd0, rx_valid},   32'd0);
        check("ack_overrun",  {31'd0, rx_overrun}, 32'd0);
        $display("overrun sequence done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
